mio_int_responder: RTL and testbench

- Memory-mapped interrupt responder on the MIO bus. It is the CPU-facing end of the interrupt handshake.
- It latches edge-triggered requests from button and timer sources into pending bits and presents one prioritised request (int_o, cause_o) to the SCPU.
- It completes the claim/acknowledge protocol through CPU loads and stores to its register window.
- It is clocked by the CPU clock and sits beside MIO_BUS as one more bus slave.

---
 rtl/mio_int_responder.sv | 159 +++++++++++++++
 tb/tb_mio_int_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mio_int_responder.sv
// ============================================================================
// mio_int_responder : MIO bus slave that latches source edges and runs the
// interrupt claim/acknowledge handshake with the SCPU.   Rev 1.0
// ============================================================================
`default_nettype none

module mio_int_responder #(
  parameter int          NSRC      = 6,
  parameter logic [31:0] BASE_ADDR = 32'hF000_0100
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NSRC-1:0] src_i,
  input  logic [31:0]     addr_bus,
  input  logic [31:0]     Cpu_data2bus,
  input  logic            mem_w,
  input  logic            rd_en,
  output logic [31:0]     Cpu_data4bus,
  output logic            int_o,
  output logic [31:0]     cause_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] OFF_PENDING = 2'd0;
  localparam logic [1:0] OFF_MASK    = 2'd1;
  localparam logic [1:0] OFF_CLAIM   = 2'd2;
  localparam logic [1:0] OFF_ACK     = 2'd3;

  state_t          state_q, state_d;
  logic [NSRC-1:0] sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [NSRC-1:0] pending_q, pending_d, mask_q, mask_d;
  logic [4:0]      claimed_idx_q, claimed_idx_d;
  logic            err_q, err_d;
  logic            int_o_q, int_o_d;
  logic [31:0]     cause_o_q, cause_o_d;

  logic            sel, bus_wr, bus_rd, ack_wr, ack_hit;
  logic [1:0]      off;
  logic [4:0]      ack_idx;
  logic [NSRC-1:0] src_edge, clr, act_q, act_d;
  logic [31:0]     rdata;
  logic            unused_bits;

  function automatic logic [4:0] lowest_idx(input logic [NSRC-1:0] v);
    lowest_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = 5'(i);
    end
  endfunction

  assign sel         = (addr_bus[31:4] == BASE_ADDR[31:4]);
  assign off         = addr_bus[3:2];
  assign bus_wr      = sel & mem_w;
  assign bus_rd      = sel & rd_en;
  assign ack_wr      = bus_wr && (off == OFF_ACK);
  assign ack_idx     = Cpu_data2bus[4:0];
  assign ack_hit     = ack_wr && (state_q == SERVICE) && (ack_idx == claimed_idx_q);
  assign src_edge    = sync2_q & ~sync3_q;
  assign act_q       = pending_q & mask_q;
  assign unused_bits = ^{addr_bus[1:0], Cpu_data2bus};

  always_comb begin
    sync1_d       = src_i;
    sync2_d       = sync1_q;
    sync3_d       = sync2_q;
    mask_d        = mask_q;
    clr           = '0;
    err_d         = err_q;
    state_d       = state_q;
    claimed_idx_d = claimed_idx_q;

    if (bus_wr && (off == OFF_MASK))    mask_d = Cpu_data2bus[NSRC-1:0];
    if (bus_wr && (off == OFF_PENDING)) clr    = Cpu_data2bus[NSRC-1:0];
    for (int i = 0; i < NSRC; i++) begin
      if (ack_hit && (5'(i) == claimed_idx_q)) clr[i] = 1'b1;
    end
    // A fresh edge outranks any clear of the same bit in the same cycle.
    pending_d = (pending_q & ~clr) | src_edge;
    act_d     = pending_d & mask_d;

    if (ack_wr) err_d = (state_q == SERVICE) && (ack_idx != claimed_idx_q);

    case (state_q)
      IDLE: begin
        if ((act_q != '0) && (act_d != '0)) state_d = REQ;
      end
      REQ: begin
        if (bus_rd && (off == OFF_CLAIM)) begin
          claimed_idx_d = lowest_idx(act_q);
          state_d       = SERVICE;
        end else if (act_d == '0) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (ack_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs track the next state so the cause register always matches hi.
    int_o_d = (state_d == REQ);
    case (state_d)
      REQ:     cause_o_d = {1'b1, 26'b0, lowest_idx(act_d)};
      SERVICE: cause_o_d = {1'b1, 26'b0, claimed_idx_d};
      default: cause_o_d = '0;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (bus_rd) begin
      case (off)
        OFF_PENDING: rdata[NSRC-1:0] = pending_q;
        OFF_MASK:    rdata[NSRC-1:0] = mask_q;
        OFF_CLAIM:   rdata           = cause_o_q;
        default:     rdata           = {31'b0, err_q};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      sync1_q       <= '0;
      sync2_q       <= '0;
      sync3_q       <= '0;
      pending_q     <= '0;
      mask_q        <= '0;
      claimed_idx_q <= '0;
      err_q         <= 1'b0;
      int_o_q       <= 1'b0;
      cause_o_q     <= '0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      sync3_q       <= sync3_d;
      pending_q     <= pending_d;
      mask_q        <= mask_d;
      claimed_idx_q <= claimed_idx_d;
      err_q         <= err_d;
      int_o_q       <= int_o_d;
      cause_o_q     <= cause_o_d;
    end
  end

  assign Cpu_data4bus = rdata;
  assign int_o        = int_o_q;
  assign cause_o      = cause_o_q;

endmodule

`default_nettype wire

// File: tb/tb_mio_int_responder.sv
// ============================================================================
// tb_mio_int_responder : directed scoreboard bench for mio_int_responder.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mio_int_responder;

  localparam int          NSRC = 6;
  localparam logic [31:0] BASE = 32'hF000_0100;
  localparam int SEL_RD = 0, SEL_INT = 1, SEL_CAUSE = 2;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NSRC-1:0] src_i;
  logic [31:0]     addr_bus, Cpu_data2bus, Cpu_data4bus, cause_o;
  logic            mem_w, rd_en, int_o;
  logic            probe;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  mio_int_responder #(.NSRC(NSRC), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .src_i        (src_i),
    .addr_bus     (addr_bus),
    .Cpu_data2bus (Cpu_data2bus),
    .mem_w        (mem_w),
    .rd_en        (rd_en),
    .Cpu_data4bus (Cpu_data4bus),
    .int_o        (int_o),
    .cause_o      (cause_o)
  );

  always #5 clk = ~clk;

  // Monitor: compares whatever the DUT presents against the queued expectations.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rd_en || probe) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty: DUT output presented with no expectation queued");
        end
        while (sb.size() > 0) begin
          exp_t        e;
          logic [31:0] got;
          e = sb.pop_front();
          case (e.sel)
            SEL_RD:  got = Cpu_data4bus;
            SEL_INT: got = {31'b0, int_o};
            default: got = cause_o;
          endcase
          checks++;
          if (got !== e.exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, got, e.exp);
          end
        end
      end
    end
  end

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    addr_bus     = addr;
    Cpu_data2bus = data;
    mem_w        = 1'b1;
    @(posedge clk);
    #1 mem_w = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    sb.push_back('{name, SEL_RD, exp});
    addr_bus = addr;
    rd_en    = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic exp_int, input logic [31:0] exp_cause);
    @(negedge clk);
    sb.push_back('{{name, "_int"}, SEL_INT, {31'b0, exp_int}});
    sb.push_back('{{name, "_cause"}, SEL_CAUSE, exp_cause});
    probe = 1'b1;
    #3 probe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; src_i = '0; addr_bus = '0; Cpu_data2bus = '0;
    mem_w = 1'b0; rd_en = 1'b0; probe = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;

    chk_out("reset_out", 1'b0, 32'h0);
    rd("reset_pending", BASE + 32'h0, 32'h0);
    rd("reset_mask",    BASE + 32'h4, 32'h0);
    rd("reset_status",  BASE + 32'hC, 32'h0);
    rd("reset_claim",   BASE + 32'h8, 32'h0);

    // Masked source: pending latches, no request.
    @(negedge clk) src_i = 6'h04;
    @(negedge clk) src_i = 6'h00;
    repeat (4) @(posedge clk);
    rd("t1_pending", BASE + 32'h0, 32'h4);
    chk_out("t1_masked", 1'b0, 32'h0);
    wr(BASE + 32'h4, 32'h3F);
    repeat (2) @(posedge clk);
    chk_out("t1_req", 1'b1, 32'h8000_0002);
    rd("t1_claim", BASE + 32'h8, 32'h8000_0002);
    chk_out("t1_service", 1'b0, 32'h8000_0002);
    wr(BASE + 32'hC, 32'h2);
    rd("t1_pending_acked", BASE + 32'h0, 32'h0);
    rd("outside_window", BASE + 32'h10, 32'h0);

    // Higher-priority arrival pre-empts before the claim.
    @(negedge clk) src_i = 6'h10;
    repeat (4) @(posedge clk);
    chk_out("t2_src4", 1'b1, 32'h8000_0004);
    @(negedge clk) src_i = 6'h12;
    repeat (4) @(posedge clk);
    chk_out("t2_preempt", 1'b1, 32'h8000_0001);
    rd("t2_claim", BASE + 32'h8, 32'h8000_0001);
    chk_out("t2_service", 1'b0, 32'h8000_0001);

    // Wrong index sets err; the right one completes the handshake.
    wr(BASE + 32'hC, 32'h3);
    rd("t3_status_err", BASE + 32'hC, 32'h1);
    rd("t3_pending_kept", BASE + 32'h0, 32'h12);
    chk_out("t3_still_service", 1'b0, 32'h8000_0001);
    wr(BASE + 32'hC, 32'h1);
    rd("t3_status_clr", BASE + 32'hC, 32'h0);
    rd("t3_pending_bit1", BASE + 32'h0, 32'h10);
    chk_out("t3_req4", 1'b1, 32'h8000_0004);

    // W1C of the only active bit drops the request.
    wr(BASE + 32'h0, 32'h10);
    chk_out("t4_idle", 1'b0, 32'h0);
    rd("t4_pending", BASE + 32'h0, 32'h0);
    @(negedge clk) src_i = 6'h00;

    // Edge on bit 0 lands in the same cycle as ACK 0.
    @(negedge clk) src_i = 6'h01;
    @(negedge clk) src_i = 6'h00;
    repeat (5) @(posedge clk);
    chk_out("t5_req0", 1'b1, 32'h8000_0000);
    rd("t5_claim", BASE + 32'h8, 32'h8000_0000);
    repeat (4) @(posedge clk);
    @(negedge clk) src_i = 6'h01;
    @(posedge clk);
    @(posedge clk);
    wr(BASE + 32'hC, 32'h0);
    chk_out("t5_ack_idle", 1'b0, 32'h0);
    rd("t5_pending_kept", BASE + 32'h0, 32'h1);
    chk_out("t5_rereq", 1'b1, 32'h8000_0000);

    // Asynchronous reset in the middle of SERVICE.
    rd("t6_claim", BASE + 32'h8, 32'h8000_0000);
    wr(BASE + 32'hC, 32'h5);
    rd("t6_status_err", BASE + 32'hC, 32'h1);
    chk_out("t6_service", 1'b0, 32'h8000_0000);
    @(posedge clk);
    #1 rstn = 1'b0;
    chk_out("t6_rst_out", 1'b0, 32'h0);
    rd("t6_rst_pending", BASE + 32'h0, 32'h0);
    rd("t6_rst_mask",    BASE + 32'h4, 32'h0);
    rd("t6_rst_status",  BASE + 32'hC, 32'h0);
    @(negedge clk) rstn = 1'b1;
    repeat (2) @(posedge clk);

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover: %0d expectations never compared, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
